microcode_sequencer: RTL and testbench

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

---
 rtl/microcode_sequencer.sv | 135 +++++++++++++
 tb/tb_microcode_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: accepts one decoded instruction at a time, fetches its
// control word from the microcode ROM, holds it through execution and retires or traps.
module microcode_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [5:0]  microcode_addr_i,
  input  logic        invalid_instruction_i,
  output logic        rom_en_o,
  output logic [5:0]  rom_addr_o,
  input  logic [18:0] rom_data_i,
  input  logic        mem_busy_i,
  output logic [18:0] control_field_o,
  output logic        control_valid_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic        trap_cause_o,
  output logic [31:0] instret_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [5:0] SYSTEM_ADDR = 6'd38;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [18:0] control_field_q;
  logic [5:0]  rom_addr_q;
  logic        trap_cause_q;
  logic        retire_q;
  logic [31:0] instret_q;

  logic        handshake;
  logic        addr_illegal;
  logic        is_system;
  logic        mem_op;
  logic        exec_done;

  // Handshake: an instruction transfers on any cycle where instr_valid_i and
  // instr_ready_o are both 1. Ready is high only in IDLE (and never in reset),
  // so valid seen in any other state is dropped, not queued.
  assign handshake    = instr_valid_i & instr_ready_o;
  assign addr_illegal = invalid_instruction_i | (microcode_addr_i > SYSTEM_ADDR);
  assign is_system    = (microcode_addr_i == SYSTEM_ADDR);

  // Stores (bit 12) and load writebacks ([11:10] = 01) wait on the load-store unit.
  assign mem_op    = control_field_q[12] | (control_field_q[11:10] == 2'b01);
  assign exec_done = (state_q == S_EXEC) & ~(mem_op & mem_busy_i);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          if (addr_illegal || is_system) begin
            state_d = S_TRAP;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          state_d = S_IDLE;
        end
      end
      S_TRAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    instr_ready_o   = (state_q == S_IDLE) & ~rst_i;
    rom_en_o        = 1'b0;
    rom_addr_o      = rom_addr_q;
    control_valid_o = (state_q == S_EXEC);
    trap_o          = (state_q == S_TRAP);
    trap_cause_o    = (state_q == S_TRAP) & trap_cause_q;
    if (handshake && !addr_illegal && !is_system) begin
      rom_en_o   = 1'b1;
      rom_addr_o = microcode_addr_i;
    end
  end

  // Datapath registers: ROM address hold, control word, trap cause, retire counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rom_addr_q      <= 6'd0;
      control_field_q <= 19'd0;
      trap_cause_q    <= 1'b0;
      retire_q        <= 1'b0;
      instret_q       <= 32'd0;
    end else begin
      retire_q <= 1'b0;
      if (rom_en_o) begin
        rom_addr_q <= microcode_addr_i;
      end
      if (handshake && (addr_illegal || is_system)) begin
        trap_cause_q <= ~addr_illegal;
      end
      if (state_q == S_FETCH) begin
        control_field_q <= rom_data_i;
      end else if (exec_done) begin
        control_field_q <= 19'd0;
        retire_q        <= 1'b1;
        instret_q       <= instret_q + 32'd1;
      end
    end
  end

  assign control_field_o = control_field_q;
  assign retire_o        = retire_q;
  assign instret_o       = instret_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed, table-driven bench for microcode_sequencer: one record per clock
// cycle with the inputs to drive and every output expected in that cycle.
module tb_microcode_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [5:0]  microcode_addr_i;
  logic        invalid_instruction_i;
  logic        rom_en_o;
  logic [5:0]  rom_addr_o;
  logic [18:0] rom_data_i;
  logic        mem_busy_i;
  logic [18:0] control_field_o;
  logic        control_valid_o;
  logic        retire_o;
  logic        trap_o;
  logic        trap_cause_o;
  logic [31:0] instret_o;
  logic [1:0]  dbg_state_o;

  int tests_run = 0;
  int tests_failed = 0;

  microcode_sequencer dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .instr_valid_i         (instr_valid_i),
    .instr_ready_o         (instr_ready_o),
    .microcode_addr_i      (microcode_addr_i),
    .invalid_instruction_i (invalid_instruction_i),
    .rom_en_o              (rom_en_o),
    .rom_addr_o            (rom_addr_o),
    .rom_data_i            (rom_data_i),
    .mem_busy_i            (mem_busy_i),
    .control_field_o       (control_field_o),
    .control_valid_o       (control_valid_o),
    .retire_o              (retire_o),
    .trap_o                (trap_o),
    .trap_cause_o          (trap_cause_o),
    .instret_o             (instret_o),
    .dbg_state_o           (dbg_state_o)
  );

  // Clock / reset block
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [5:0]  addr;
    logic        inv;
    logic [18:0] rom;
    logic        busy;
    logic        e_ready;
    logic        e_en;
    logic [5:0]  e_raddr;
    logic [18:0] e_cf;
    logic        e_cv;
    logic        e_ret;
    logic        e_trap;
    logic        e_cause;
    logic [31:0] e_instret;
  } vec_t;

  vec_t tbl[$];

  localparam logic [18:0] JUNK = 19'h7FFFF;

  function automatic vec_t mk(logic rst, logic valid, logic [5:0] addr, logic inv,
                              logic [18:0] rom, logic busy, logic e_ready, logic e_en,
                              logic [5:0] e_raddr, logic [18:0] e_cf, logic e_cv,
                              logic e_ret, logic e_trap, logic e_cause, logic [31:0] e_instret);
    vec_t v;
    v.rst = rst; v.valid = valid; v.addr = addr; v.inv = inv; v.rom = rom; v.busy = busy;
    v.e_ready = e_ready; v.e_en = e_en; v.e_raddr = e_raddr; v.e_cf = e_cf; v.e_cv = e_cv;
    v.e_ret = e_ret; v.e_trap = e_trap; v.e_cause = e_cause; v.e_instret = e_instret;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Driver: inputs change just after the falling edge, outputs are checked 1ns later.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk_i);
    rst_i                 = v.rst;
    instr_valid_i         = v.valid;
    microcode_addr_i      = v.addr;
    invalid_instruction_i = v.inv;
    rom_data_i            = v.rom;
    mem_busy_i            = v.busy;
    #1;
    chk("instr_ready",   idx, 32'(instr_ready_o),   32'(v.e_ready));
    chk("rom_en",        idx, 32'(rom_en_o),        32'(v.e_en));
    chk("rom_addr",      idx, 32'(rom_addr_o),      32'(v.e_raddr));
    chk("control_field", idx, 32'(control_field_o), 32'(v.e_cf));
    chk("control_valid", idx, 32'(control_valid_o), 32'(v.e_cv));
    chk("retire",        idx, 32'(retire_o),        32'(v.e_ret));
    chk("trap",          idx, 32'(trap_o),          32'(v.e_trap));
    chk("trap_cause",    idx, 32'(trap_cause_o),    32'(v.e_cause));
    chk("instret",       idx, instret_o,            v.e_instret);
  endtask

  initial begin
    rst_i = 1'b1;
    instr_valid_i = 1'b0;
    microcode_addr_i = 6'd0;
    invalid_instruction_i = 1'b0;
    rom_data_i = 19'd0;
    mem_busy_i = 1'b0;

    //                rst v  addr  inv rom          busy rdy en raddr cf          cv ret trp cau instret
    // reset holds everything low, even with a valid offered
    tbl.push_back(mk(1, 1, 6'd18, 0, JUNK,         0,   0,  0, 6'd0,  19'h0,      0, 0,  0,  0,  0));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   1,  0, 6'd0,  19'h0,      0, 0,  0,  0,  0));
    // non-memory op at 18; mem_busy ignored in EXEC
    tbl.push_back(mk(0, 1, 6'd18, 0, JUNK,         0,   1,  1, 6'd18, 19'h0,      0, 0,  0,  0,  0));
    tbl.push_back(mk(0, 1, 6'd5,  1, 19'h0_020C,   0,   0,  0, 6'd18, 19'h0,      0, 0,  0,  0,  0));
    tbl.push_back(mk(0, 1, 6'd5,  0, JUNK,         1,   0,  0, 6'd18, 19'h0_020C, 1, 0,  0,  0,  0));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         1,   1,  0, 6'd18, 19'h0,      0, 1,  0,  0,  1));
    // load writeback at 12, stalled 4 EXEC cycles
    tbl.push_back(mk(0, 1, 6'd12, 0, JUNK,         0,   1,  1, 6'd12, 19'h0,      0, 0,  0,  0,  1));
    tbl.push_back(mk(0, 0, 6'd0,  0, 19'h0_0455,   1,   0,  0, 6'd12, 19'h0,      0, 0,  0,  0,  1));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         1,   0,  0, 6'd12, 19'h0_0455, 1, 0,  0,  0,  1));
    tbl.push_back(mk(0, 1, 6'd3,  0, JUNK,         1,   0,  0, 6'd12, 19'h0_0455, 1, 0,  0,  0,  1));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         1,   0,  0, 6'd12, 19'h0_0455, 1, 0,  0,  0,  1));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         1,   0,  0, 6'd12, 19'h0_0455, 1, 0,  0,  0,  1));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   0,  0, 6'd12, 19'h0_0455, 1, 0,  0,  0,  1));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   1,  0, 6'd12, 19'h0,      0, 1,  0,  0,  2));
    // store at 3, stalled one cycle
    tbl.push_back(mk(0, 1, 6'd3,  0, JUNK,         0,   1,  1, 6'd3,  19'h0,      0, 0,  0,  0,  2));
    tbl.push_back(mk(0, 0, 6'd0,  0, 19'h0_1000,   1,   0,  0, 6'd3,  19'h0,      0, 0,  0,  0,  2));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         1,   0,  0, 6'd3,  19'h0_1000, 1, 0,  0,  0,  2));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   0,  0, 6'd3,  19'h0_1000, 1, 0,  0,  0,  2));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   1,  0, 6'd3,  19'h0,      0, 1,  0,  0,  3));
    // illegal flag, then out-of-range 45, then system 38, then boundary 39
    tbl.push_back(mk(0, 1, 6'd7,  1, JUNK,         0,   1,  0, 6'd3,  19'h0,      0, 0,  0,  0,  3));
    tbl.push_back(mk(0, 1, 6'd20, 0, JUNK,         0,   0,  0, 6'd3,  19'h0,      0, 0,  1,  0,  3));
    tbl.push_back(mk(0, 1, 6'd45, 0, JUNK,         0,   1,  0, 6'd3,  19'h0,      0, 0,  0,  0,  3));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   0,  0, 6'd3,  19'h0,      0, 0,  1,  0,  3));
    tbl.push_back(mk(0, 1, 6'd38, 0, JUNK,         0,   1,  0, 6'd3,  19'h0,      0, 0,  0,  0,  3));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   0,  0, 6'd3,  19'h0,      0, 0,  1,  1,  3));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   1,  0, 6'd3,  19'h0,      0, 0,  0,  0,  3));
    tbl.push_back(mk(0, 1, 6'd39, 0, JUNK,         0,   1,  0, 6'd3,  19'h0,      0, 0,  0,  0,  3));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   0,  0, 6'd3,  19'h0,      0, 0,  1,  0,  3));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   1,  0, 6'd3,  19'h0,      0, 0,  0,  0,  3));
    // reset during FETCH
    tbl.push_back(mk(0, 1, 6'd10, 0, JUNK,         0,   1,  1, 6'd10, 19'h0,      0, 0,  0,  0,  3));
    tbl.push_back(mk(1, 0, 6'd0,  0, 19'h0_0400,   0,   0,  0, 6'd0,  19'h0,      0, 0,  0,  0,  0));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   1,  0, 6'd0,  19'h0,      0, 0,  0,  0,  0));
    // reset during a stalled EXEC
    tbl.push_back(mk(0, 1, 6'd12, 0, JUNK,         0,   1,  1, 6'd12, 19'h0,      0, 0,  0,  0,  0));
    tbl.push_back(mk(0, 0, 6'd0,  0, 19'h0_0455,   1,   0,  0, 6'd12, 19'h0,      0, 0,  0,  0,  0));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         1,   0,  0, 6'd12, 19'h0_0455, 1, 0,  0,  0,  0));
    tbl.push_back(mk(1, 0, 6'd0,  0, JUNK,         1,   0,  0, 6'd0,  19'h0,      0, 0,  0,  0,  0));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   1,  0, 6'd0,  19'h0,      0, 0,  0,  0,  0));
    tbl.push_back(mk(0, 0, 6'd0,  0, JUNK,         0,   1,  0, 6'd0,  19'h0,      0, 0,  0,  0,  0));

    foreach (tbl[i]) apply(tbl[i], i);

    // instret wrap: preload all-ones, then two back-to-back instructions
    @(negedge clk_i);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    apply(mk(0, 1, 6'd1, 0, JUNK,       0, 1, 1, 6'd1, 19'h0, 0, 0, 0, 0, 32'hFFFF_FFFF), 100);
    apply(mk(0, 0, 6'd0, 0, 19'h0_0001, 0, 0, 0, 6'd1, 19'h0, 0, 0, 0, 0, 32'hFFFF_FFFF), 101);
    apply(mk(0, 0, 6'd0, 0, JUNK,       0, 0, 0, 6'd1, 19'h1, 1, 0, 0, 0, 32'hFFFF_FFFF), 102);
    apply(mk(0, 1, 6'd2, 0, JUNK,       0, 1, 1, 6'd2, 19'h0, 0, 1, 0, 0, 32'h0),         103);
    apply(mk(0, 0, 6'd0, 0, 19'h0_0003, 0, 0, 0, 6'd2, 19'h0, 0, 0, 0, 0, 32'h0),         104);
    apply(mk(0, 0, 6'd0, 0, JUNK,       0, 0, 0, 6'd2, 19'h3, 1, 0, 0, 0, 32'h0),         105);
    apply(mk(0, 0, 6'd0, 0, JUNK,       0, 1, 0, 6'd2, 19'h0, 0, 1, 0, 0, 32'h1),         106);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
